// File: rtl/emif_pkg.sv
// rtl/emif_pkg.sv - shared state encoding, chip-select encoding and timing defaults for emif_master
package emif_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } emif_state_t;

    // req_cs encoding: which active-low chip select a request drives
    localparam logic CS_SEL_NCS5 = 1'b0;
    localparam logic CS_SEL_NCS2 = 1'b1;

    localparam int unsigned DEF_T_SETUP  = 2;
    localparam int unsigned DEF_T_STROBE = 8;
    localparam int unsigned DEF_T_HOLD   = 2;
    localparam int unsigned DEF_T_TURN   = 2;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    // The responder decodes its register index as {A[22:0], A[23]}, so rotate right by one
    function automatic logic [ADDR_W-1:0] emif_map_addr(input logic [ADDR_W-1:0] addr);
        return {addr[0], addr[ADDR_W-1:1]};
    endfunction

endpackage

// File: rtl/emif_iobuf.sv
// rtl/emif_iobuf.sv - tristate driver for the EMIF data bus
module emif_iobuf
    import emif_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         oe,
    input  logic [W-1:0] dout,
    output logic [W-1:0] din,
    inout  wire  [W-1:0] pad
);

    assign pad = oe ? dout : {W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/emif_master.sv
// rtl/emif_master.sv - EMIF bus master running one SETUP/STROBE/HOLD/TURN cycle per request
module emif_master
    import emif_pkg::*;
#(
    parameter int unsigned T_SETUP  = DEF_T_SETUP,
    parameter int unsigned T_STROBE = DEF_T_STROBE,
    parameter int unsigned T_HOLD   = DEF_T_HOLD,
    parameter int unsigned T_TURN   = DEF_T_TURN
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_cs,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              EMIF_NCS5,
    output logic              EMIF_NCS2,
    output logic              EMIF_NWE,
    output logic              EMIF_NOE,
    output logic [ADDR_W-1:0] EMIF_A,
    inout  wire  [DATA_W-1:0] EMIF_D
);

    // Counter reload values: a state lasting N cycles counts N-1 down to 0
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_TURN   = CNT_W'(T_TURN - 1);

    emif_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] rd_cap;
    logic              rd_pend;
    logic              d_oe;

    emif_iobuf #(
        .W(DATA_W)
    ) u_iobuf (
        .oe   (d_oe),
        .dout (wdata_q),
        .din  (din),
        .pad  (EMIF_D)
    );

    // Bus-cycle sequencer; every pin and status output is a flop updated on the edge entering its state
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rd_cap    <= '0;
            rd_pend   <= 1'b0;
            d_oe      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            EMIF_NCS5 <= 1'b1;
            EMIF_NCS2 <= 1'b1;
            EMIF_NWE  <= 1'b1;
            EMIF_NOE  <= 1'b1;
            EMIF_A    <= '0;
        end else begin
            // Read data captured at the end of STROBE is presented one cycle later
            rsp_valid <= rd_pend;
            rd_pend   <= 1'b0;
            if (rd_pend) begin
                rsp_rdata <= rd_cap;
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_wr;
                        wdata_q   <= req_wdata;
                        EMIF_A    <= emif_map_addr(req_addr);
                        EMIF_NCS5 <= (req_cs != CS_SEL_NCS5);
                        EMIF_NCS2 <= (req_cs != CS_SEL_NCS2);
                        d_oe      <= req_wr;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (T_SETUP != 0) begin
                            state <= ST_SETUP;
                            cnt   <= LD_SETUP;
                        end else begin
                            state    <= ST_STROBE;
                            cnt      <= LD_STROBE;
                            EMIF_NWE <= !req_wr;
                            EMIF_NOE <= req_wr;
                        end
                    end
                end

                ST_SETUP: begin
                    if (cnt == '0) begin
                        state    <= ST_STROBE;
                        cnt      <= LD_STROBE;
                        EMIF_NWE <= !wr_q;
                        EMIF_NOE <= wr_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (cnt == '0) begin
                        EMIF_NWE <= 1'b1;
                        EMIF_NOE <= 1'b1;
                        if (!wr_q) begin
                            rd_cap  <= din;
                            rd_pend <= 1'b1;
                        end
                        if (T_HOLD != 0) begin
                            state <= ST_HOLD;
                            cnt   <= LD_HOLD;
                        end else begin
                            EMIF_NCS5 <= 1'b1;
                            EMIF_NCS2 <= 1'b1;
                            d_oe      <= 1'b0;
                            if (T_TURN != 0) begin
                                state <= ST_TURN;
                                cnt   <= LD_TURN;
                            end else begin
                                state     <= ST_IDLE;
                                req_ready <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt == '0) begin
                        EMIF_NCS5 <= 1'b1;
                        EMIF_NCS2 <= 1'b1;
                        d_oe      <= 1'b0;
                        if (T_TURN != 0) begin
                            state <= ST_TURN;
                            cnt   <= LD_TURN;
                        end else begin
                            state     <= ST_IDLE;
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_TURN: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emif_master.sv
// tb/tb_emif_master.sv - directed self-checking bench for emif_master with a register responder model
module tb_emif_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        z_valid;
    logic        req_wr;
    logic        req_cs;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;

    logic        req_ready, rsp_valid, busy, ncs5, ncs2, nwe, noe;
    logic [15:0] rsp_rdata;
    logic [23:0] ea;
    wire  [15:0] ed;

    logic        z_ready, z_rsp_valid, z_busy, z_ncs5, z_ncs2, z_nwe, z_noe;
    logic [15:0] z_rdata;
    logic [23:0] za;
    wire  [15:0] zd;

    always #5 clk = ~clk;

    emif_master dut0 (
        .sys_clk(clk), .sys_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_cs(req_cs),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .EMIF_NCS5(ncs5), .EMIF_NCS2(ncs2), .EMIF_NWE(nwe), .EMIF_NOE(noe),
        .EMIF_A(ea), .EMIF_D(ed)
    );

    emif_master #(.T_SETUP(0), .T_STROBE(4), .T_HOLD(0), .T_TURN(0)) dutz (
        .sys_clk(clk), .sys_rst(rst),
        .req_valid(z_valid), .req_ready(z_ready), .req_wr(req_wr), .req_cs(req_cs),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .busy(z_busy),
        .EMIF_NCS5(z_ncs5), .EMIF_NCS2(z_ncs2), .EMIF_NWE(z_nwe), .EMIF_NOE(z_noe),
        .EMIF_A(za), .EMIF_D(zd)
    );

    // Responder: register index is {A[22:0], A[23]}, low 8 bits kept
    logic [15:0] mem [0:255];
    bit          mem_init = 1'b0;

    function automatic logic [7:0] ridx(input logic [23:0] a);
        return {a[6:0], a[23]};
    endfunction

    assign ed = (!noe && !(ncs5 && ncs2)) ? mem[ridx(ea)] : 16'hzzzz;
    assign zd = (!z_noe && !(z_ncs5 && z_ncs2)) ? mem[ridx(za)] : 16'hzzzz;

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
            mem[3]   = 16'hBEEF;
            mem_init = 1'b1;
        end
        if (!nwe && !(ncs5 && ncs2)) mem[ridx(ea)] = ed;
        if (!z_nwe && !(z_ncs5 && z_ncs2)) mem[ridx(za)] = zd;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int n_cs5, n_cs2, n_we, n_oe, n_rsp, n_bad_d, n_ready_busy, n_ready_early;
    int first_cs, first_stb, last_stb, rel_idx, rsp_idx, hs_idx;
    logic [23:0] a_seen;

    // Sample dut0 once per cycle at the falling edge; k=0 is the first cycle after the handshake
    task automatic mon(input int cycles, input bit hold);
        bit drop;
        drop = !hold;
        n_cs5 = 0; n_cs2 = 0; n_we = 0; n_oe = 0; n_rsp = 0; n_bad_d = 0;
        n_ready_busy = 0; n_ready_early = 0;
        first_cs = -1; first_stb = -1; last_stb = -1; rel_idx = -1; rsp_idx = -1; hs_idx = -1;
        a_seen = 24'h0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (drop) req_valid = 1'b0;
            if (!ncs5 || !ncs2) begin
                if (first_cs < 0) first_cs = k;
                if (rel_idx < 0) a_seen = ea;
            end else if (first_cs >= 0 && rel_idx < 0) begin
                rel_idx = k;
            end
            if (!ncs5) n_cs5++;
            if (!ncs2) n_cs2++;
            if (!nwe || !noe) begin
                if (first_stb < 0) first_stb = k;
                last_stb = k;
            end
            if (!nwe) n_we++;
            if (!noe) n_oe++;
            if (rsp_valid) begin
                n_rsp++;
                if (rsp_idx < 0) rsp_idx = k;
            end
            if (req_wr && (!ncs5 || !ncs2)) begin
                if (dut0.d_oe !== 1'b1 || ed !== req_wdata) n_bad_d++;
            end else if (dut0.d_oe !== 1'b0) begin
                n_bad_d++;
            end
            if (req_ready && busy) n_ready_busy++;
            if (req_ready && hs_idx < 0 && rel_idx < 0) n_ready_early++;
            if (hold && hs_idx < 0 && req_valid && req_ready) begin
                hs_idx = k;
                drop   = 1'b1;
            end
        end
    endtask

    int zfirst_cs, zfirst_stb, zrel, zhs, zn_rsp, zn_oe;
    bit zdrop;

    initial begin
        rst = 1'b1; req_valid = 1'b0; z_valid = 1'b0;
        req_wr = 1'b0; req_cs = 1'b0; req_addr = 24'h0; req_wdata = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ncs5", ncs5, 1);
        chk("rst_ncs2", ncs2, 1);
        chk("rst_nwe", nwe, 1);
        chk("rst_noe", noe, 1);
        chk("rst_addr", ea, 24'h0);
        chk("rst_d_oe", dut0.d_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 16'h0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);

        // Default write of 0x1234 to 0x12 on CS5
        req_valid = 1'b1; req_wr = 1'b1; req_cs = 1'b0; req_addr = 24'h12; req_wdata = 16'h1234;
        mon(16, 1'b0);
        chk("wr_ncs5_cycles", n_cs5, 12);
        chk("wr_ncs2_cycles", n_cs2, 0);
        chk("wr_nwe_cycles", n_we, 8);
        chk("wr_noe_cycles", n_oe, 0);
        chk("wr_setup_cycles", first_stb - first_cs, 2);
        chk("wr_addr", a_seen, 24'h000009);
        chk("wr_data_bus", n_bad_d, 0);
        chk("wr_no_rsp", n_rsp, 0);
        chk("wr_ready_busy", n_ready_busy, 0);

        // Default read of 0x03 on CS2, responder returns 0xBEEF
        req_valid = 1'b1; req_wr = 1'b0; req_cs = 1'b1; req_addr = 24'h03;
        mon(16, 1'b0);
        chk("rd_ncs2_cycles", n_cs2, 12);
        chk("rd_ncs5_cycles", n_cs5, 0);
        chk("rd_noe_cycles", n_oe, 8);
        chk("rd_nwe_cycles", n_we, 0);
        chk("rd_addr", a_seen, 24'h800001);
        chk("rd_rsp_count", n_rsp, 1);
        chk("rd_rsp_latency", rsp_idx, last_stb + 2);
        chk("rd_rdata", rsp_rdata, 16'hBEEF);
        chk("rd_bus_released", n_bad_d, 0);

        // Back-to-back writes with req_valid held
        req_valid = 1'b1; req_wr = 1'b1; req_cs = 1'b0; req_addr = 24'h05; req_wdata = 16'h1111;
        mon(32, 1'b1);
        chk("b2b_release_idx", rel_idx, 12);
        chk("b2b_hs_after_release", (hs_idx + 1) - rel_idx, 3);
        chk("b2b_ready_low", n_ready_early, 0);
        chk("b2b_ncs5_total", n_cs5, 24);
        chk("b2b_nwe_total", n_we, 16);

        // Reset asserted in the middle of a write strobe
        req_valid = 1'b1; req_wr = 1'b1; req_cs = 1'b0; req_addr = 24'h07; req_wdata = 16'h5A5A;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_strobe", nwe, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_nwe", nwe, 1);
        chk("abort_noe", noe, 1);
        chk("abort_ncs5", ncs5, 1);
        chk("abort_d_oe", dut0.d_oe, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_no_rsp", rsp_valid, 0);

        // Loopback: write 0xA5A5 to 0x20 and read it back
        req_valid = 1'b1; req_wr = 1'b1; req_cs = 1'b0; req_addr = 24'h20; req_wdata = 16'hA5A5;
        mon(16, 1'b0);
        req_valid = 1'b1; req_wr = 1'b0; req_cs = 1'b0; req_addr = 24'h20;
        mon(16, 1'b0);
        chk("loop_rsp_count", n_rsp, 1);
        chk("loop_rdata", rsp_rdata, 16'hA5A5);

        // Zero setup/hold/turn instance: two held reads of 0x03 on CS2
        zfirst_cs = -1; zfirst_stb = -1; zrel = -1; zhs = -1; zn_rsp = 0; zn_oe = 0; zdrop = 1'b0;
        req_wr = 1'b0; req_cs = 1'b1; req_addr = 24'h03;
        z_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (zdrop) z_valid = 1'b0;
            if (!z_ncs2 && zfirst_cs < 0) zfirst_cs = k;
            if (!z_noe && zfirst_stb < 0) zfirst_stb = k;
            if (!z_noe) zn_oe++;
            if (z_ncs2 && zfirst_cs >= 0 && zrel < 0) zrel = k;
            if (z_valid && z_ready && zhs < 0) begin
                zhs   = k;
                zdrop = 1'b1;
            end
            if (z_rsp_valid) zn_rsp++;
        end
        chk("z_cs_first", zfirst_cs, 0);
        chk("z_strobe_with_cs", zfirst_stb, zfirst_cs);
        chk("z_release_idx", zrel, 4);
        chk("z_hs_after_release", (zhs + 1) - zrel, 1);
        chk("z_noe_cycles", zn_oe, 8);
        chk("z_rsp_count", zn_rsp, 2);
        chk("z_rdata", z_rdata, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/emif_master.md
EMIF_MASTER -- requirements
Module: emif_master

Interface
REQ-001 The block SHALL use one clock, sys_clk; reset sys_rst SHALL be asynchronous and active-high.
REQ-002 Parameters, one per line (name, default, meaning):
- T_SETUP, 2, cycles of address/CS valid before strobe (0 allowed).
- T_STROBE, 8, cycles of NWE/NOE low (minimum 1).
- T_HOLD, 2, cycles after strobe release before CS release (0 allowed).
- T_TURN, 2, idle cycles between bus cycles (0 allowed).
REQ-003 Ports, one per line (name, direction, width, meaning):
- sys_clk, in, 1, clock.
- sys_rst, in, 1, async active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted when valid&ready.
- req_wr, in, 1, 1 = write, 0 = read.
- req_cs, in, 1, 0 = NCS5, 1 = NCS2.
- req_addr, in, 24, register word address.
- req_wdata, in, 16, write data.
- rsp_valid, out, 1, one-cycle read-data strobe.
- rsp_rdata, out, 16, read data.
- busy, out, 1, bus cycle in progress.
- EMIF_NCS5, out, 1, chip select 5, active-low.
- EMIF_NCS2, out, 1, chip select 2, active-low.
- EMIF_NWE, out, 1, write strobe, active-low.
- EMIF_NOE, out, 1, output enable, active-low.
- EMIF_A, out, 24, address pins.
- EMIF_D, inout, 16, data bus.

Function
REQ-004 EMIF_A SHALL be {req_addr[0], req_addr[23:1]}, matching the responder's {A[22:0],A[23]} register mapping.
REQ-005 FSM states SHALL be IDLE, SETUP, STROBE, HOLD, TURN.
REQ-006 req_ready SHALL be 1 only in IDLE; the handshake SHALL latch wr, cs, addr and wdata and leave IDLE on the next edge.
REQ-007 IDLE->SETUP on handshake; SETUP is skipped (direct to STROBE) when T_SETUP=0.
REQ-008 Each timed state SHALL last exactly its parameter in cycles, using one down-counter reloaded on entry.
REQ-009 STROBE->HOLD, or ->TURN when T_HOLD=0; HOLD->TURN, or ->IDLE when T_TURN=0; TURN->IDLE.
REQ-010 The selected NCS SHALL be low from SETUP entry through HOLD end; all outputs SHALL be registered with no glitches.
REQ-011 NWE (write) or NOE (read) SHALL be low exactly during STROBE; the unselected strobe SHALL stay high.
REQ-012 EMIF_D SHALL be driven with latched wdata from SETUP through HOLD for writes, and SHALL be high-Z otherwise.
REQ-013 For reads, EMIF_D SHALL be sampled on the last STROBE cycle; rsp_valid SHALL pulse 1 cycle later with rsp_rdata held until the next read.
REQ-014 Writes SHALL produce no rsp_valid.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Back-to-back requests: at most one cycle in IDLE between bus cycles; req_valid held during a cycle is ignored until IDLE.
REQ-017 The block SHALL NOT check T_STROBE against responder sync latency; integrators SHALL set T_STROBE >= 6 for the 3-flop-synchronised responder.

Reset
REQ-018 On reset: state IDLE; NCS5/NCS2/NWE/NOE = 1; EMIF_A = 0; EMIF_D high-Z; rsp_valid = 0; rsp_rdata = 0; busy = 0.
REQ-019 Reset mid-cycle SHALL release all strobes and the data bus immediately (asynchronously); no rsp_valid SHALL be issued for the aborted cycle.

Structure
REQ-020 A shared package emif_pkg SHALL hold the state enum, the CS select encoding and the default timing constants.
REQ-021 The tristate driver SHALL live in one sub-module, emif_iobuf (oe, dout, din, pad).

Verification
REQ-022 Write 0x1234 to addr 0x12 on CS5, defaults: NCS5 low 12 cycles, NWE low 8 cycles, A = 0x000009 | bit23 = 0, D = 0x1234 throughout, no rsp_valid.
REQ-023 Read addr 0x03 on CS2 with the responder model returning 0xBEEF: NOE low 8 cycles, rsp_valid 1 cycle after NOE rises, rsp_rdata = 0xBEEF, A[23] = 1.
REQ-024 T_SETUP=0, T_HOLD=0, T_TURN=0: strobe falls together with CS; next request accepted 1 cycle after CS rises.
REQ-025 Two requests (req_valid held): second handshake occurs exactly T_TURN+1 cycles after the first cycle's CS release; req_ready = 0 throughout the first cycle.
REQ-026 sys_rst asserted during STROBE of a write: within the same cycle all strobes = 1 and D = Z; after release, FSM in IDLE with req_ready = 1.
REQ-027 Writer-to-responder loopback: write then read back addr 0x20 with 0xA5A5 returns 0xA5A5.
